cache_miss_handler: RTL

//  Request front-end for the K-way CLOCK cache. Takes one read request at a time, looks it up on the

---
 rtl/cache_miss_handler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cache_miss_handler.sv
// Single-outstanding read front-end for the CLOCK cache: lookup on ch1, on miss fetch from memory,
// install via ch1 write (waiting out eviction), then respond. All outputs are registered.
module cache_miss_handler #(
   parameter int ADDR_WIDTH = 8,
   parameter int LINE_WIDTH = 32,
   parameter int WR_TIMEOUT = 16
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   output logic                  o_resp_valid,
   input  logic                  i_resp_ready,
   output logic [LINE_WIDTH-1:0] o_resp_data,
   output logic                  o_resp_from_mem,
   output logic                  o_resp_err,
   output logic [ADDR_WIDTH-1:0] o_c_addr,
   output logic [LINE_WIDTH-1:0] o_c_wdata,
   output logic                  o_c_read,
   output logic                  o_c_write,
   input  logic                  i_c_hit,
   input  logic [LINE_WIDTH-1:0] i_c_rdata,
   output logic                  o_mem_req_valid,
   input  logic                  i_mem_req_ready,
   output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
   input  logic                  i_mem_resp_valid,
   input  logic [LINE_WIDTH-1:0] i_mem_resp_data
);

   localparam int CW = $clog2(WR_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WR_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(WR_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_CHECK, S_MEM_REQ, S_MEM_WAIT, S_FILL, S_RESP
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr_q;
   logic [LINE_WIDTH-1:0] r_data_q;
   logic [CW-1:0]         r_cnt;
   logic                  r_req_ready;
   logic                  r_resp_valid;
   logic [LINE_WIDTH-1:0] r_resp_data;
   logic                  r_resp_from_mem;
   logic                  r_resp_err;
   logic [ADDR_WIDTH-1:0] r_c_addr;
   logic [LINE_WIDTH-1:0] r_c_wdata;
   logic                  r_c_read;
   logic                  r_c_write;
   logic                  r_mem_req_valid;
   logic [ADDR_WIDTH-1:0] r_mem_req_addr;

   // The cache's hit register only reflects our write from the second FILL edge on.
   logic w_fill_hit;
   assign w_fill_hit = (r_cnt != '0) && i_c_hit;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state         <= S_IDLE;
         r_addr_q        <= '0;
         r_data_q        <= '0;
         r_cnt           <= '0;
         r_req_ready     <= 1'b1;
         r_resp_valid    <= 1'b0;
         r_resp_data     <= '0;
         r_resp_from_mem <= 1'b0;
         r_resp_err      <= 1'b0;
         r_c_addr        <= '0;
         r_c_wdata       <= '0;
         r_c_read        <= 1'b0;
         r_c_write       <= 1'b0;
         r_mem_req_valid <= 1'b0;
         r_mem_req_addr  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_addr_q    <= i_req_addr;
                  r_req_ready <= 1'b0;
                  r_c_read    <= 1'b1;
                  r_c_addr    <= i_req_addr;
                  r_state     <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               r_c_read <= 1'b0;
               r_c_addr <= '0;
               r_state  <= S_CHECK;
            end
            S_CHECK: begin
               if (i_c_hit) begin
                  r_resp_valid    <= 1'b1;
                  r_resp_data     <= i_c_rdata;
                  r_resp_from_mem <= 1'b0;
                  r_state         <= S_RESP;
               end else begin
                  r_mem_req_valid <= 1'b1;
                  r_mem_req_addr  <= r_addr_q;
                  r_state         <= S_MEM_REQ;
               end
            end
            S_MEM_REQ: begin
               if (i_mem_req_ready) begin
                  r_mem_req_valid <= 1'b0;
                  r_mem_req_addr  <= '0;
                  r_state         <= S_MEM_WAIT;
               end
            end
            S_MEM_WAIT: begin
               if (i_mem_resp_valid) begin
                  r_data_q  <= i_mem_resp_data;
                  r_c_write <= 1'b1;
                  r_c_addr  <= r_addr_q;
                  r_c_wdata <= i_mem_resp_data;
                  r_cnt     <= '0;
                  r_state   <= S_FILL;
               end
            end
            S_FILL: begin
               // Timing out on edge WR_TIMEOUT keeps c_write asserted for exactly WR_TIMEOUT edges.
               if (w_fill_hit || r_cnt == CNT_LAST) begin
                  r_c_write       <= 1'b0;
                  r_c_addr        <= '0;
                  r_c_wdata       <= '0;
                  r_resp_valid    <= 1'b1;
                  r_resp_data     <= r_data_q;
                  r_resp_from_mem <= 1'b1;
                  r_resp_err      <= !w_fill_hit;
                  r_state         <= S_RESP;
               end
               if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
            end
            S_RESP: begin
               if (i_resp_ready) begin
                  r_resp_valid    <= 1'b0;
                  r_resp_data     <= '0;
                  r_resp_from_mem <= 1'b0;
                  r_resp_err      <= 1'b0;
                  r_req_ready     <= 1'b1;
                  r_state         <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_req_ready     = r_req_ready;
   assign o_resp_valid    = r_resp_valid;
   assign o_resp_data     = r_resp_data;
   assign o_resp_from_mem = r_resp_from_mem;
   assign o_resp_err      = r_resp_err;
   assign o_c_addr        = r_c_addr;
   assign o_c_wdata       = r_c_wdata;
   assign o_c_read        = r_c_read;
   assign o_c_write       = r_c_write;
   assign o_mem_req_valid = r_mem_req_valid;
   assign o_mem_req_addr  = r_mem_req_addr;

endmodule
